// File: rtl/bus_scheduler.sv
// Arbitrates control-mode, setpoint and periodic status-request frames for motors
// sharing one half-duplex UART bus, and supervises the status reply window.
module bus_scheduler #(
    parameter int NUMBER_OF_MOTORS  = 8,
    parameter int RX_TIMEOUT_CYCLES = 1400
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 status_period_cycles,
    input  logic [NUMBER_OF_MOTORS-1:0] ctrl_req,
    input  logic [NUMBER_OF_MOTORS-1:0] sp_req,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [1:0]                  cmd_type,
    output logic [7:0]                  cmd_motor,
    input  logic                        tx_frame_done,
    input  logic                        rx_status_valid,
    input  logic [7:0]                  rx_motor_id,
    output logic                        status_ok,
    output logic                        status_timeout,
    output logic                        busy
);
    localparam logic [1:0]  TYPE_STATUS = 2'd0;
    localparam logic [1:0]  TYPE_SP     = 2'd1;
    localparam logic [1:0]  TYPE_CTRL   = 2'd2;
    localparam logic [7:0]  LAST_MOTOR  = 8'(NUMBER_OF_MOTORS - 1);
    localparam logic [31:0] RX_TIMEOUT  = 32'(RX_TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_TX, WAIT_RX} state_t;

    state_t                      state_q, state_d;
    logic [NUMBER_OF_MOTORS-1:0] ctrl_pend_q, ctrl_pend_d;
    logic [NUMBER_OF_MOTORS-1:0] sp_pend_q, sp_pend_d;
    logic                        status_due_q, status_due_d;
    logic [31:0]                 period_cnt_q, period_cnt_d;
    logic [31:0]                 rx_tmo_q, rx_tmo_d;
    logic [7:0]                  rr_q, rr_d;
    logic [1:0]                  cmd_type_q, cmd_type_d;
    logic [7:0]                  cmd_motor_q, cmd_motor_d;
    logic                        status_ok_q, status_ok_d;
    logic                        status_timeout_q, status_timeout_d;

    logic                        accept;
    logic [NUMBER_OF_MOTORS-1:0] motor_sel;
    logic [7:0]                  ctrl_idx, sp_idx;

    assign cmd_valid      = (state_q == OFFER);
    assign busy           = (state_q != IDLE);
    assign cmd_type       = cmd_type_q;
    assign cmd_motor      = cmd_motor_q;
    assign status_ok      = status_ok_q;
    assign status_timeout = status_timeout_q;
    assign accept         = cmd_valid & cmd_ready;

    // Descending scan: the last hit written is the lowest pending index.
    always_comb begin
        ctrl_idx  = '0;
        sp_idx    = '0;
        motor_sel = '0;
        for (int i = NUMBER_OF_MOTORS - 1; i >= 0; i--) begin
            if (ctrl_pend_q[i]) ctrl_idx = 8'(i);
            if (sp_pend_q[i])   sp_idx   = 8'(i);
            motor_sel[i] = (cmd_motor_q == 8'(i));
        end
    end

    // Pending bits, status slot timer and round-robin pointer; a request pulse
    // always wins over a clear landing in the same cycle.
    always_comb begin
        ctrl_pend_d  = ctrl_pend_q;
        sp_pend_d    = sp_pend_q;
        status_due_d = status_due_q;
        period_cnt_d = period_cnt_q - 32'd1;
        rr_d         = rr_q;
        if (accept && cmd_type_q == TYPE_CTRL) begin
            ctrl_pend_d = ctrl_pend_d & ~motor_sel;
            sp_pend_d   = sp_pend_d & ~motor_sel;
        end
        if (accept && cmd_type_q == TYPE_SP) begin
            sp_pend_d = sp_pend_d & ~motor_sel;
        end
        if (accept && cmd_type_q == TYPE_STATUS) begin
            status_due_d = 1'b0;
            rr_d         = (rr_q == LAST_MOTOR) ? 8'd0 : rr_q + 8'd1;
        end
        if (period_cnt_q == 32'd0) begin
            period_cnt_d = status_period_cycles;
            status_due_d = 1'b1;
        end
        ctrl_pend_d = ctrl_pend_d | ctrl_req;
        sp_pend_d   = sp_pend_d | sp_req;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        cmd_type_d       = cmd_type_q;
        cmd_motor_d      = cmd_motor_q;
        rx_tmo_d         = rx_tmo_q;
        status_ok_d      = 1'b0;
        status_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|ctrl_pend_q) begin
                    cmd_type_d  = TYPE_CTRL;
                    cmd_motor_d = ctrl_idx;
                    state_d     = OFFER;
                end else if (|sp_pend_q) begin
                    cmd_type_d  = TYPE_SP;
                    cmd_motor_d = sp_idx;
                    state_d     = OFFER;
                end else if (status_due_q) begin
                    cmd_type_d  = TYPE_STATUS;
                    cmd_motor_d = rr_q;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (cmd_ready) state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_frame_done) begin
                    if (cmd_type_q == TYPE_STATUS) begin
                        state_d  = WAIT_RX;
                        rx_tmo_d = RX_TIMEOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RX: begin
                // A matching reply in the final cycle still counts as on time.
                if (rx_status_valid && rx_motor_id == cmd_motor_q) begin
                    status_ok_d = 1'b1;
                    rx_tmo_d    = 32'd0;
                    state_d     = IDLE;
                end else if (rx_tmo_q <= 32'd1) begin
                    status_timeout_d = 1'b1;
                    rx_tmo_d         = 32'd0;
                    state_d          = IDLE;
                end else begin
                    rx_tmo_d = rx_tmo_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            ctrl_pend_q      <= '0;
            sp_pend_q        <= '0;
            status_due_q     <= 1'b0;
            period_cnt_q     <= 32'd0;
            rx_tmo_q         <= 32'd0;
            rr_q             <= 8'd0;
            cmd_type_q       <= 2'd0;
            cmd_motor_q      <= 8'd0;
            status_ok_q      <= 1'b0;
            status_timeout_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            ctrl_pend_q      <= ctrl_pend_d;
            sp_pend_q        <= sp_pend_d;
            status_due_q     <= status_due_d;
            period_cnt_q     <= period_cnt_d;
            rx_tmo_q         <= rx_tmo_d;
            rr_q             <= rr_d;
            cmd_type_q       <= cmd_type_d;
            cmd_motor_q      <= cmd_motor_d;
            status_ok_q      <= status_ok_d;
            status_timeout_q <= status_timeout_d;
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: directed scenarios plus randomized traffic
// compared against a transaction-level model of pending requests and status rotation.
module tb_bus_scheduler;
    localparam int N          = 4;
    localparam int T          = 24;
    localparam int WAIT_BOUND = 400;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  status_period_cycles = 32'd100;
    logic [N-1:0] ctrl_req = '0;
    logic [N-1:0] sp_req = '0;
    logic         cmd_valid;
    logic         cmd_ready = 1'b0;
    logic [1:0]   cmd_type;
    logic [7:0]   cmd_motor;
    logic         tx_frame_done = 1'b0;
    logic         rx_status_valid = 1'b0;
    logic [7:0]   rx_motor_id = 8'd0;
    logic         status_ok;
    logic         status_timeout;
    logic         busy;

    bus_scheduler #(.NUMBER_OF_MOTORS(N), .RX_TIMEOUT_CYCLES(T)) dut (
        .clk                  (clk),
        .reset                (reset),
        .status_period_cycles (status_period_cycles),
        .ctrl_req             (ctrl_req),
        .sp_req               (sp_req),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_type             (cmd_type),
        .cmd_motor            (cmd_motor),
        .tx_frame_done        (tx_frame_done),
        .rx_status_valid      (rx_status_valid),
        .rx_motor_id          (rx_motor_id),
        .status_ok            (status_ok),
        .status_timeout       (status_timeout),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ok_count = 0;

    // Reference model: outstanding requests per motor and the next status target.
    bit ctrl_p [N];
    bit sp_p   [N];
    int rr_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            ctrl_p[i] = 1'b0;
            sp_p[i]   = 1'b0;
        end
        rr_m = 0;
    endfunction

    function automatic void model_set(input logic [N-1:0] c, input logic [N-1:0] s);
        for (int i = 0; i < N; i++) begin
            if (c[i]) ctrl_p[i] = 1'b1;
            if (s[i]) sp_p[i]   = 1'b1;
        end
    endfunction

    function automatic int first_set(input bit v [N]);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit any_pending();
        return (first_set(ctrl_p) >= 0) || (first_set(sp_p) >= 0);
    endfunction

    function automatic void predict(output int typ, output int mot);
        int c_i, s_i;
        c_i = first_set(ctrl_p);
        s_i = first_set(sp_p);
        if (c_i >= 0) begin
            typ = 2; mot = c_i;
        end else if (s_i >= 0) begin
            typ = 1; mot = s_i;
        end else begin
            typ = 0; mot = rr_m;
        end
    endfunction

    task automatic pulse_reqs(input logic [N-1:0] c, input logic [N-1:0] s);
        ctrl_req = c;
        sp_req   = s;
        tick();
        ctrl_req = '0;
        sp_req   = '0;
        model_set(c, s);
    endtask

    task automatic wait_valid(output bit seen);
        int waited = 0;
        while (!cmd_valid && waited < WAIT_BOUND) begin
            tick();
            waited++;
        end
        seen = cmd_valid;
        check("cmd_valid_seen", 32'(cmd_valid), 32'd1);
    endtask

    // One full command: offer, optional hold, accept, frame done and, for status, the reply.
    // req_mode 1 injects random requests; rx_mode 0 random, 1 matching reply, 2 no matching reply.
    task automatic do_cmd(input int req_mode, input int rx_mode);
        int typ, mot, mode, d, wrong, cnt;
        bit seen, got_ok;
        logic [N-1:0] c, s;
        wait_valid(seen);
        if (!seen) return;
        predict(typ, mot);
        check("cmd_type", 32'(cmd_type), 32'(typ));
        check("cmd_motor", 32'(cmd_motor), 32'(mot));
        repeat ($urandom_range(0, 3)) begin
            c = (req_mode == 1 && $urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            s = (req_mode == 1 && $urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            pulse_reqs(c, s);
            check("hold_valid", 32'(cmd_valid), 32'd1);
            check("hold_type", 32'(cmd_type), 32'(typ));
            check("hold_motor", 32'(cmd_motor), 32'(mot));
        end
        c = '0;
        s = '0;
        if (req_mode == 1 && $urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 1) == 1) c = N'(1) << mot;
            else s = N'(1) << mot;
        end
        cmd_ready = 1'b1;
        ctrl_req  = c;
        sp_req    = s;
        tick();
        cmd_ready = 1'b0;
        ctrl_req  = '0;
        sp_req    = '0;
        if (typ == 2) begin
            ctrl_p[mot] = 1'b0;
            sp_p[mot]   = 1'b0;
        end else if (typ == 1) begin
            sp_p[mot] = 1'b0;
        end else begin
            rr_m = (rr_m + 1) % N;
        end
        model_set(c, s);
        check("valid_after_accept", 32'(cmd_valid), 32'd0);
        check("busy_in_flight", 32'(busy), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        tx_frame_done = 1'b1;
        tick();
        tx_frame_done = 1'b0;
        if (typ != 0) begin
            check("busy_after_done", 32'(busy), 32'd0);
            return;
        end
        mode = (rx_mode == 0) ? int'($urandom_range(1, 2)) : rx_mode;
        if (mode == 1) begin
            d = $urandom_range(1, T);
            repeat (d - 1) tick();
            rx_status_valid = 1'b1;
            rx_motor_id     = 8'(mot);
            tick();
            rx_status_valid = 1'b0;
            check("status_ok", 32'(status_ok), 32'd1);
            check("no_timeout_on_reply", 32'(status_timeout), 32'd0);
            if (status_ok) ok_count++;
        end else begin
            wrong  = $urandom_range(1, T);
            cnt    = 0;
            got_ok = 1'b0;
            while (cnt < 2 * T && !status_timeout) begin
                if (cnt + 1 == wrong) begin
                    rx_status_valid = 1'b1;
                    rx_motor_id     = 8'((mot + 1) % N);
                end
                tick();
                rx_status_valid = 1'b0;
                cnt++;
                if (status_ok) got_ok = 1'b1;
            end
            check("timeout_latency", 32'(cnt), 32'(T));
            check("no_ok_on_wrong_id", 32'(got_ok), 32'd0);
        end
        check("idle_after_status", 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;
        int idle_valid;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_type", 32'(cmd_type), 32'd0);
        check("rst_cmd_motor", 32'(cmd_motor), 32'd0);
        check("rst_status_ok", 32'(status_ok), 32'd0);
        check("rst_status_timeout", 32'(status_timeout), 32'd0);
        reset = 1'b0;

        // Periodic status rotation 0,1,2,3,0 with matching replies.
        repeat (5) do_cmd(0, 1);
        check("status_ok_count", 32'(ok_count), 32'd5);

        // Motor 1 never answers; a reply carrying id 2 is ignored.
        do_cmd(0, 2);

        // Reset while waiting for motor 2's reply.
        wait_valid(seen);
        check("pre_reset_motor", 32'(cmd_motor), 32'd2);
        cmd_ready = 1'b1;
        tick();
        cmd_ready     = 1'b0;
        tx_frame_done = 1'b1;
        tick();
        tx_frame_done = 1'b0;
        repeat (3) tick();
        check("busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        status_period_cycles = 32'd50000;
        #1;
        check("busy_in_reset", 32'(busy), 32'd0);
        check("valid_in_reset", 32'(cmd_valid), 32'd0);
        repeat (3) begin
            tick();
            check("no_ok_after_abort", 32'(status_ok), 32'd0);
            check("no_tmo_after_abort", 32'(status_timeout), 32'd0);
        end
        reset = 1'b0;
        model_reset();
        repeat (3) begin
            tick();
            check("no_ok_after_release", 32'(status_ok), 32'd0);
            check("no_tmo_after_release", 32'(status_timeout), 32'd0);
        end
        do_cmd(0, 1);

        // Simultaneous setpoint and control requests: control first, then setpoint.
        pulse_reqs(N'(4'b0010), N'(4'b0100));
        do_cmd(0, 0);
        do_cmd(0, 0);

        // A setpoint queued behind a control request for the same motor is absorbed.
        pulse_reqs(N'(4'b1000), '0);
        pulse_reqs('0, N'(4'b1000));
        do_cmd(0, 0);
        idle_valid = 0;
        repeat (20) begin
            tick();
            if (cmd_valid) idle_valid++;
        end
        check("no_followup_setpoint", 32'(idle_valid), 32'd0);

        // Offer stays frozen for 50 cycles while further setpoint requests arrive.
        pulse_reqs('0, N'(4'b0001));
        wait_valid(seen);
        repeat (50) begin
            pulse_reqs('0, N'($urandom));
            check("stall_valid", 32'(cmd_valid), 32'd1);
            check("stall_type", 32'(cmd_type), 32'd1);
            check("stall_motor", 32'(cmd_motor), 32'd0);
        end
        for (int k = 0; k < 3 * N && any_pending(); k++) do_cmd(0, 0);

        // Randomized traffic with back-to-back status slots.
        reset = 1'b1;
        status_period_cycles = 32'd0;
        tick();
        reset = 1'b0;
        model_reset();
        repeat (60) do_cmd(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
